// File: rtl/fp16_pkg.sv
// Shared definitions for the 16-bit floating-point word used by add_fp and fp_to_int.
// Field layout: [15] sign, [14:10] biased exponent, [9:0] mantissa (no hidden bit).
package fp16_pkg;

  localparam int FP_W     = 16;
  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 10;
  localparam int MAN_MSB  = 9;
  localparam int EXP_W    = 5;
  localparam int MAN_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } fsm_state_e;

endpackage

// File: rtl/fp_to_int_if.sv
// Handshake bundle between the FP datapath, the converter and the integer write port.
interface fp_to_int_if #(
  parameter int OUT_W = 16
);
  import fp16_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [FP_W-1:0]  fp_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] int_out;
  logic             ovf;

  modport master (
    output in_valid, fp_in, out_ready,
    input  in_ready, out_valid, int_out, ovf
  );

  modport slave (
    input  in_valid, fp_in, out_ready,
    output in_ready, out_valid, int_out, ovf
  );
endinterface

// File: rtl/fp_to_int.sv
// Sequential FP16 -> saturated two's-complement integer converter.
// Aligns the mantissa one bit per cycle; truncates toward zero and saturates on overflow.
module fp_to_int
  import fp16_pkg::*;
#(
  parameter int BIAS  = 15,
  parameter int OUT_W = 16
) (
  input logic        clk,
  input logic        rst,
  fp_to_int_if.slave bus
);

  localparam int CNT_W = EXP_W + 1;

  fsm_state_e       state;
  logic             sign_r;
  logic             left_r;
  logic [OUT_W-1:0] mag_r;
  logic [CNT_W-1:0] cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [OUT_W-1:0] int_out_r;
  logic             ovf_out_r;

  logic [EXP_W-1:0] exp_in;
  logic [OUT_W-1:0] man_zext;
  logic [CNT_W-1:0] cnt_in;
  logic             left_in;
  logic             zero_in;
  logic [OUT_W-1:0] mag_shl;
  logic [OUT_W-1:0] mag_shr;
  logic             left_ovf;

  function automatic logic [OUT_W-1:0] sat_result(input logic neg,
                                                  input logic [OUT_W-1:0] mag,
                                                  input logic sat);
    if (sat)
      return neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  always_comb begin
    exp_in   = bus.fp_in[EXP_MSB:EXP_LSB];
    man_zext = OUT_W'(bus.fp_in[MAN_MSB:0]);
    zero_in  = (bus.fp_in[EXP_MSB:0] == '0);
    left_in  = (int'(exp_in) > BIAS);
    if (left_in)
      cnt_in = CNT_W'(int'(exp_in) - BIAS);
    else
      cnt_in = CNT_W'(BIAS - int'(exp_in));
    mag_shl  = {mag_r[OUT_W-2:0], 1'b0};
    mag_shr  = {1'b0, mag_r[OUT_W-1:1]};
    // Bit shifted out, or new MSB set (value above the positive maximum).
    left_ovf = mag_r[OUT_W-1] | mag_r[OUT_W-2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      sign_r      <= 1'b0;
      left_r      <= 1'b0;
      mag_r       <= '0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      int_out_r   <= '0;
      ovf_out_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            in_ready_r <= 1'b0;
            sign_r     <= bus.fp_in[SIGN_BIT];
            mag_r      <= man_zext;
            cnt_r      <= cnt_in;
            left_r     <= left_in;
            if (zero_in || cnt_in == '0) begin
              state       <= ST_DONE;
              out_valid_r <= 1'b1;
              int_out_r   <= sat_result(bus.fp_in[SIGN_BIT], man_zext, 1'b0);
              ovf_out_r   <= 1'b0;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          cnt_r <= cnt_r - 1'b1;
          if (left_r) begin
            mag_r <= mag_shl;
            if (left_ovf) begin
              state       <= ST_DONE;
              out_valid_r <= 1'b1;
              int_out_r   <= sat_result(sign_r, mag_shl, 1'b1);
              ovf_out_r   <= 1'b1;
            end else if (cnt_r == CNT_W'(1)) begin
              state       <= ST_DONE;
              out_valid_r <= 1'b1;
              int_out_r   <= sat_result(sign_r, mag_shl, 1'b0);
              ovf_out_r   <= 1'b0;
            end
          end else begin
            mag_r <= mag_shr;
            if (mag_shr == '0 || cnt_r == CNT_W'(1)) begin
              state       <= ST_DONE;
              out_valid_r <= 1'b1;
              int_out_r   <= sat_result(sign_r, mag_shr, 1'b0);
              ovf_out_r   <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.int_out   = int_out_r;
  assign bus.ovf       = ovf_out_r;

endmodule

// File: tb/tb_fp_to_int.sv
// Directed and random checks of fp_to_int against an arithmetic reference model.
module tb_fp_to_int;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_to_int_if #(.OUT_W(16)) bus_if ();

  fp_to_int #(.BIAS(15), .OUT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value = (-1)^s * M * 2^(E-15), truncated toward zero, saturated to 16 bits.
  // k is the number of alignment cycles including the early exits.
  function automatic void model(input logic [15:0] fp, output logic [15:0] val,
                                output logic o, output int k);
    int     e;
    int     cnt;
    longint m;
    longint mag;
    e   = int'(fp[14:10]) - 15;
    cnt = (e < 0) ? -e : e;
    m   = longint'(fp[9:0]);
    o   = 1'b0;
    k   = 0;
    if (fp[14:0] != 15'd0 && cnt != 0) begin
      for (int i = 1; i <= cnt; i++) begin
        k = i;
        if (e > 0 && m * (longint'(1) << i) > 32767) begin
          o = 1'b1;
          break;
        end
        if (e < 0 && (m / (longint'(1) << i)) == 0) break;
      end
    end
    mag = (e > 0) ? m * (longint'(1) << k) : m / (longint'(1) << k);
    if (o) val = fp[15] ? 16'h8000 : 16'h7FFF;
    else   val = fp[15] ? 16'(-mag) : 16'(mag);
  endfunction

  task automatic convert(input logic [15:0] fp);
    logic [15:0] exp_val;
    logic        exp_ovf;
    int          exp_k;
    int          n;
    int          lat;
    model(fp, exp_val, exp_ovf, exp_k);
    n = 0;
    while (!bus_if.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("ready_%h", fp), 32'(bus_if.in_ready), 32'd1);
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.fp_in    = fp;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    bus_if.fp_in    = 16'($urandom);
    lat = 0;
    while (!bus_if.out_valid && lat < 40) begin
      lat++;
      if (lat > 1) begin @(posedge clk); #1; end
      else if (bus_if.out_valid) break;
    end
    if (lat == 0) lat = 1;
    check($sformatf("lat_%h", fp), 32'(lat), 32'(exp_k + 1));
    check($sformatf("val_%h", fp), 32'(bus_if.int_out), 32'(exp_val));
    check($sformatf("ovf_%h", fp), 32'(bus_if.ovf), 32'(exp_ovf));
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    check($sformatf("release_%h", fp), 32'(bus_if.out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] held;
    bus_if.in_valid  = 1'b0;
    bus_if.fp_in     = '0;
    bus_if.out_ready = 1'b0;

    #12;
    check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_int_out", 32'(bus_if.int_out), 32'd0);
    check("rst_ovf", 32'(bus_if.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // out_ready while idle must not disturb anything
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    check("idle_out_ready_valid", 32'(bus_if.out_valid), 32'd0);
    check("idle_out_ready_ready", 32'(bus_if.in_ready), 32'd1);

    convert(16'h0000);
    convert(16'h3C05);
    convert(16'hBC05);
    convert(16'h4803);
    convert(16'hB40A);
    convert(16'h0001);
    convert(16'h7FFF);
    convert(16'hFFFF);
    convert(16'h8000);
    convert(16'h7C00);
    convert(16'h3800);
    convert(16'h7801);

    // Backpressure: result held, new word not accepted
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.fp_in    = 16'h4803;
    @(posedge clk); #1;
    bus_if.fp_in = 16'h3C05;
    for (int i = 0; i < 10 && !bus_if.out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp_valid", 32'(bus_if.out_valid), 32'd1);
    held = bus_if.int_out;
    check("bp_first", 32'(held), 32'd24);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_%0d", i), 32'(bus_if.int_out), 32'd24);
      check($sformatf("bp_ready_%0d", i), 32'(bus_if.in_ready), 32'd0);
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    check("bp_release", 32'(bus_if.out_valid), 32'd0);

    // Reset in the middle of a 10-cycle right shift
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.fp_in    = 16'h03FF;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus_if.in_ready), 32'd1);
    check("mid_rst_valid", 32'(bus_if.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_quiet_%0d", i), 32'(bus_if.out_valid), 32'd0);
    end
    convert(16'h3C05);

    for (int i = 0; i < 60; i++) convert(16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
